// File: rtl/csa_pkg.sv
// Shared types and defaults for the carry-save accumulator controller.
package csa_pkg;

  localparam int W_DEF       = 8;
  localparam int MAX_OPS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    OUT
  } state_e;

  // Ceiling log2, used to size the accumulator so MAX_OPS full-scale operands fit.
  function automatic int clog2_ops(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/csa_3to2_eq.sv
// Equal-width 3:2 compressor: a + b + c == s + c_sh (mod 2^N), carry pre-shifted.
module csa_3to2_eq #(
  parameter int N = 12
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] s_o,
  output logic [N-1:0] c_sh_o
);

  logic [N-1:0] maj;

  assign s_o    = a_i ^ b_i ^ c_i;
  assign maj    = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  // The carry out of the top bit is dropped, giving modulo-2^N behaviour.
  assign c_sh_o = {maj[N-2:0], 1'b0};

endmodule

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: folds one operand per beat into carry-save form, resolves once per packet.
// Optional overflow flag output out_ovf is built when CSA_OVF_EN is defined.
module csa_accum_ctrl
  import csa_pkg::*;
#(
  parameter  int W       = W_DEF,
  parameter  int MAX_OPS = MAX_OPS_DEF,
  localparam int ACC_W   = W + clog2_ops(MAX_OPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data
`ifdef CSA_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CNT_W = clog2_ops(MAX_OPS + 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [ACC_W-1:0]   carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   x_ext;
  logic [ACC_W-1:0]   csa_s, csa_c;
  logic               accept;

`ifdef CSA_OVF_EN
  logic               ovf_q, ovf_d;
  logic               out_ovf_q, out_ovf_d;
`endif

  assign x_ext     = ACC_W'(in_data);
  assign in_ready  = rst_n && (state_q == IDLE || state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef CSA_OVF_EN
  assign out_ovf   = out_ovf_q;
`endif

  csa_3to2_eq #(.N(ACC_W)) u_csa (
    .a_i    (sum_q),
    .b_i    (carry_q),
    .c_i    (x_ext),
    .s_o    (csa_s),
    .c_sh_o (csa_c)
  );

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    state_d     = state_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef CSA_OVF_EN
    ovf_d       = ovf_q;
    out_ovf_d   = out_ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sum_d   = x_ext;
          carry_d = '0;
          cnt_d   = CNT_W'(1);
`ifdef CSA_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = in_last ? RESOLVE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          sum_d   = csa_s;
          carry_d = csa_c;
          cnt_d   = cnt_q + CNT_W'(1);
`ifdef CSA_OVF_EN
          if (cnt_q == CNT_W'(MAX_OPS)) ovf_d = 1'b1;
`endif
          if (in_last) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        out_data_d  = sum_q + carry_q;
        out_valid_d = 1'b1;
`ifdef CSA_OVF_EN
        out_ovf_d   = ovf_q;
`endif
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef CSA_OVF_EN
      ovf_q       <= 1'b0;
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef CSA_OVF_EN
      ovf_q       <= ovf_d;
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Scoreboard bench for csa_accum_ctrl; out_ovf is checked only when CSA_OVF_EN is defined.
module tb_csa_accum_ctrl;
  import csa_pkg::*;

  localparam int W       = W_DEF;
  localparam int MAX_OPS = MAX_OPS_DEF;
  localparam int ACC_W   = W + clog2_ops(MAX_OPS);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
`ifdef CSA_OVF_EN
  logic             out_ovf;
`endif

  csa_accum_ctrl #(.W(W), .MAX_OPS(MAX_OPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef CSA_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               vectors;
  int               miscompares;
  logic [W-1:0]     ops[$];
  logic [ACC_W-1:0] exp_q[$];
  bit               exp_ovf_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives the beats in ops; gap idle cycles follow the first beat. Returns at the
  // negedge after the final accept. finish=0 sends no last flag and expects no result.
  task automatic send_pkt(input int gap, input bit finish);
    logic [ACC_W-1:0] acc;
    int               n;
    int               k;
    acc = '0;
    n   = 0;
    foreach (ops[i]) begin
      if (i == 1) repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = ops[i];
      in_last  = finish && (i == ops.size() - 1);
      k = 0;
      while (!in_ready && k < 40) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      acc = acc + ACC_W'(ops[i]);
      n++;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_last  = 1'($urandom);
    end
    if (finish) begin
      exp_q.push_back(acc);
      exp_ovf_q.push_back(n > MAX_OPS);
    end
  endtask

  // Called at the negedge right after the last accept (controller in RESOLVE).
  task automatic collect(input int hold);
    int               k;
    logic [ACC_W-1:0] exp_d;
    bit               exp_o;
    check("ready_resolve", 32'(in_ready), 32'd0);
    check("valid_resolve", 32'(out_valid), 32'd0);
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    exp_d = exp_q.pop_front();
    exp_o = exp_ovf_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("hold_data", 32'(out_data), 32'(exp_d));
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    check("result", 32'(out_data), 32'(exp_d));
`ifdef CSA_OVF_EN
    check("ovf", 32'(out_ovf), 32'(exp_o));
`else
    if (exp_o) begin end
`endif
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_after_hs", 32'(out_valid), 32'd0);
    check("ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  task automatic fill(input int n, input logic [W-1:0] v);
    ops.delete();
    for (int i = 0; i < n; i++) ops.push_back(v);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    out_ready   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
`ifdef CSA_OVF_EN
    check("rst_ovf", 32'(out_ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    ops = '{8'h15, 8'h2A, 8'h3F};
    send_pkt(0, 1'b1);
    collect(0);

    ops = '{8'hFF};
    send_pkt(0, 1'b1);
    collect(0);

    fill(16, 8'hFF);
    send_pkt(0, 1'b1);
    collect(0);

    ops = '{8'h01, 8'h02};
    send_pkt(3, 1'b1);
    collect(5);

    // Starts on the cycle right after the previous handshake; wraps modulo 2^ACC_W.
    fill(17, 8'hFF);
    send_pkt(0, 1'b1);
    collect(0);

    ops = '{8'h01};
    send_pkt(0, 1'b1);
    collect(0);

    ops = '{8'h10, 8'h20};
    send_pkt(0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ops = '{8'h05};
    send_pkt(0, 1'b1);
    collect(0);

    for (int p = 0; p < 8; p++) begin
      ops.delete();
      for (int i = 0; i < int'($urandom_range(1, MAX_OPS)); i++)
        ops.push_back(W'($urandom));
      send_pkt(int'($urandom_range(0, 2)), 1'b1);
      collect(int'($urandom_range(0, 3)));
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
